// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage, IF/ID and ID:
// datapath widths, reset/bubble constants, fetch FSM encoding and an
// address-alignment helper.
package if_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_PRESENT = 2'd3
  } fetch_state_t;

  // Force a redirect target onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_redirect_buf.sv
// Redirect buffer: remembers the last branch/jump target seen before the
// current instruction is consumed, and selects the PC to fetch next.
module if_redirect_buf
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              consume,
  output logic [ADDR_W-1:0] next_pc
);

  logic              redirect_pending_r;
  logic [ADDR_W-1:0] redirect_pc_r;

  // Capture a redirect outside the consume cycle (last one wins); consume clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pending_r <= 1'b0;
      redirect_pc_r      <= '0;
    end else if (consume) begin
      redirect_pending_r <= 1'b0;
    end else if (branch_taken) begin
      redirect_pending_r <= 1'b1;
      redirect_pc_r      <= word_align(branch_target);
    end else begin
      redirect_pending_r <= redirect_pending_r;
    end
  end

  // Next PC priority: live redirect, then buffered redirect, then sequential.
  always_comb begin
    next_pc = pc + PC_STEP;
    if (branch_taken) begin
      next_pc = word_align(branch_target);
    end else if (redirect_pending_r) begin
      next_pc = redirect_pc_r;
    end else begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding request
// to instruction memory and hands each fetched word to IF/ID. A redirect
// from ID lands after the instruction in flight (the delay slot).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_cur_instaddress,
  output logic [ADDR_W-1:0] if_next_instaddress,
  output logic              if_valid
);

  fetch_state_t      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] next_pc_s;
  logic              consume_s;

  // The presented instruction leaves IF/ID on any unstalled PRESENT cycle.
  assign consume_s = (state_r == S_PRESENT) && !stall;

  if_redirect_buf u_redirect_buf (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc_r),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .consume       (consume_s),
    .next_pc       (next_pc_s)
  );

  // Fetch FSM with registered memory-request and IF/ID outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r             <= S_IDLE;
      pc_r                <= RESET_PC;
      inst_req            <= 1'b0;
      inst_addr           <= '0;
      if_inst             <= NOP_INST;
      if_cur_instaddress  <= '0;
      if_next_instaddress <= '0;
      if_valid            <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // Memory responses here are stale and deliberately ignored.
          state_r   <= S_REQ;
          inst_req  <= 1'b1;
          inst_addr <= pc_r;
        end
        S_REQ: begin
          // Address holds until accepted; an early data_ok is a protocol error and dropped.
          if (inst_addr_ok) begin
            state_r  <= S_WAIT;
            inst_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            state_r             <= S_PRESENT;
            if_inst             <= inst_rdata;
            if_cur_instaddress  <= pc_r;
            if_next_instaddress <= pc_r + PC_STEP;
            if_valid            <= 1'b1;
          end
        end
        S_PRESENT: begin
          // Addresses keep their last value while the bubble is shown.
          if (!stall) begin
            state_r   <= S_REQ;
            pc_r      <= next_pc_s;
            inst_req  <= 1'b1;
            inst_addr <= next_pc_s;
            if_inst   <= NOP_INST;
            if_valid  <= 1'b0;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          inst_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a table of fetch transactions
// (redirects, stalls, memory delays) driven through a bench-side memory
// model, with presented instructions checked against a scoreboard queue.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic [31:0] if_inst;
  logic [31:0] if_cur_instaddress;
  logic [31:0] if_next_instaddress;
  logic        if_valid;

  if_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .inst_req            (inst_req),
    .inst_addr           (inst_addr),
    .inst_addr_ok        (inst_addr_ok),
    .inst_data_ok        (inst_data_ok),
    .inst_rdata          (inst_rdata),
    .if_inst             (if_inst),
    .if_cur_instaddress  (if_cur_instaddress),
    .if_next_instaddress (if_next_instaddress),
    .if_valid            (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp_addr;   // address this transaction must fetch
    int          addr_dly;   // cycles addr_ok is withheld
    int          data_dly;   // cycles data_ok is withheld
    logic        br_wait;    // redirect in first WAIT cycle
    logic [31:0] tgt_wait;
    int          stall_cyc;  // stall cycles while presenting
    logic        br_stl;     // redirect in first stall cycle
    logic [31:0] tgt_stl;
    logic        br_cons;    // redirect in the consume cycle
    logic [31:0] tgt_cons;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] cur;
    logic [31:0] nxt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) + 32'h0000_0101;
  endfunction

  task automatic wait_req();
    int n;
    n = 0;
    while (inst_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, inst_req}, 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    wait_req();
    chk("req_addr", inst_addr, v.exp_addr);
    // Withhold acceptance; request must stay up with a stable address.
    for (int i = 0; i < v.addr_dly; i++) begin
      inst_addr_ok = 1'b0;
      tick();
      chk("req_hold", {31'd0, inst_req}, 32'd1);
      chk("addr_hold", inst_addr, v.exp_addr);
    end
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    // WAIT: optionally delay data, optionally redirect in the first cycle.
    for (int i = 0; i < v.data_dly; i++) begin
      branch_taken  = (i == 0) ? v.br_wait : 1'b0;
      branch_target = v.tgt_wait;
      tick();
      branch_taken = 1'b0;
      chk("wait_valid", {31'd0, if_valid}, 32'd0);
      chk("wait_inst", if_inst, 32'h0);
      chk("wait_req", {31'd0, inst_req}, 32'd0);
    end
    branch_taken  = (v.data_dly == 0) ? v.br_wait : 1'b0;
    branch_target = v.tgt_wait;
    inst_data_ok  = 1'b1;
    inst_rdata    = mem_word(v.exp_addr);
    sb.push_back('{inst: mem_word(v.exp_addr), cur: v.exp_addr, nxt: v.exp_addr + 32'd4});
    tick();
    inst_data_ok = 1'b0;
    branch_taken = 1'b0;
    // PRESENT: compare against scoreboard.
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      e = '{inst: 32'h0, cur: 32'h0, nxt: 32'h0};
    end else begin
      e = sb.pop_front();
    end
    chk("pres_valid", {31'd0, if_valid}, 32'd1);
    chk("pres_inst", if_inst, e.inst);
    chk("pres_cur", if_cur_instaddress, e.cur);
    chk("pres_next", if_next_instaddress, e.nxt);
    for (int i = 0; i < v.stall_cyc; i++) begin
      stall         = 1'b1;
      branch_taken  = (i == 0) ? v.br_stl : 1'b0;
      branch_target = v.tgt_stl;
      tick();
      branch_taken = 1'b0;
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_inst", if_inst, e.inst);
      chk("stall_cur", if_cur_instaddress, e.cur);
      chk("stall_req", {31'd0, inst_req}, 32'd0);
    end
    stall         = 1'b0;
    branch_taken  = v.br_cons;
    branch_target = v.tgt_cons;
    tick();
    branch_taken = 1'b0;
    chk("bub_valid", {31'd0, if_valid}, 32'd0);
    chk("bub_inst", if_inst, 32'h0);
    chk("bub_cur", if_cur_instaddress, e.cur);
    chk("bub_next", if_next_instaddress, e.nxt);
  endtask

  initial begin
    //         addr          ad dd bw  tw             st bs  ts             bc  tc
    vecs[0]  = '{32'hBFC00000, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{32'hBFC00004, 0, 0, 1'b0, 32'h0,        5, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{32'hBFC00008, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{32'hBFC0000C, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{32'hBFC00010, 0, 0, 1'b1, 32'h80001000, 0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{32'h80001000, 0, 0, 1'b1, 32'h80000100, 1, 1'b1, 32'h80000200, 1'b0, 32'h0};
    vecs[6]  = '{32'h80000200, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b1, 32'h80000302};
    vecs[7]  = '{32'h80000300, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{32'hFFFFFFFC, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[9]  = '{32'h00000000, 3, 4, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{32'h00000004, 0, 2, 1'b0, 32'h0,        2, 1'b0, 32'h0,        1'b0, 32'h0};

    // Reset state.
    rst = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_cur", if_cur_instaddress, 32'h0);
    chk("rst_next", if_next_instaddress, 32'h0);
    rst = 1'b1;
    tick();
    chk("first_req", {31'd0, inst_req}, 32'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while WAITing with a buffered redirect, then a stale data_ok.
    wait_req();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok  = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h80000000;
    tick();
    branch_taken = 1'b0;
    rst          = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEADBEEF;
    #1;
    chk("arst_req", {31'd0, inst_req}, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("mrst_inst", if_inst, 32'h0);
    chk("mrst_cur", if_cur_instaddress, 32'h0);
    chk("mrst_next", if_next_instaddress, 32'h0);
    chk("mrst_addr", inst_addr, 32'h0);
    rst = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    chk("stale_valid", {31'd0, if_valid}, 32'd0);
    chk("stale_inst", if_inst, 32'h0);
    chk("restart_req", {31'd0, inst_req}, 32'd1);
    chk("restart_addr", inst_addr, 32'hBFC00000);
    run_txn('{32'hBFC00000, 0, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0});
    run_txn('{32'hBFC00004, 1, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0});

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
